// File: rtl/instr_decode_stage_pkg.sv
// Shared types and opcode constants for the instruction decode stage.
// FP opcodes are decoded only when DECODE_FP_EN is defined; the constants exist either way.
package instr_decode_stage_pkg;

   typedef enum logic [2:0] {
      TypeR       = 3'd0,
      TypeI       = 3'd1,
      TypeS       = 3'd2,
      TypeB       = 3'd3,
      TypeU       = 3'd4,
      TypeJ       = 3'd5,
      TypeR4      = 3'd6,
      TypeUnknown = 3'd7
   } instr_type_e;

   localparam int unsigned TYPE_W = 3;

   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
   localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
   localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
   localparam logic [6:0] OPC_MADD     = 7'b1000011;
   localparam logic [6:0] OPC_MSUB     = 7'b1000111;
   localparam logic [6:0] OPC_NMSUB    = 7'b1001011;
   localparam logic [6:0] OPC_NMADD    = 7'b1001111;

   function automatic logic [2:0] popcount4(input logic [3:0] v);
      popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction

endpackage

// File: rtl/instr_lane_decode.sv
// Combinational decode of one instruction lane: type, immediate and register fields.
// DECODE_FP_EN adds FP opcodes and the rs3 field.
module instr_lane_decode
   import instr_decode_stage_pkg::*;
(
   input  logic        i_present,
   input  logic [31:0] i_instr,
   output logic [2:0]  o_type,
   output logic [31:0] o_imm,
   output logic [4:0]  o_rd,
   output logic [4:0]  o_rs1,
   output logic [4:0]  o_rs2,
`ifdef DECODE_FP_EN
   output logic [4:0]  o_rs3,
`endif
   output logic        o_illegal
);

   instr_type_e w_type;
   logic [6:0]  w_opcode;

   assign w_opcode = i_instr[6:0];

   always_comb begin
      w_type = TypeUnknown;
      if (i_present && (i_instr[1:0] == 2'b11)) begin
         case (w_opcode)
            OPC_OP:                                     w_type = TypeR;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: w_type = TypeI;
            OPC_STORE:                                  w_type = TypeS;
            OPC_BRANCH:                                 w_type = TypeB;
            OPC_LUI, OPC_AUIPC:                         w_type = TypeU;
            OPC_JAL:                                    w_type = TypeJ;
`ifdef DECODE_FP_EN
            OPC_LOAD_FP:                                w_type = TypeI;
            OPC_STORE_FP:                               w_type = TypeS;
            OPC_OP_FP:                                  w_type = TypeR;
            OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD:   w_type = TypeR4;
`endif
            default:                                    w_type = TypeUnknown;
         endcase
      end
   end

   always_comb begin
      o_imm = '0;
      case (w_type)
         TypeI: o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
         TypeS: o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         TypeB: o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                         i_instr[11:8], 1'b0};
         TypeU: o_imm = {i_instr[31:12], 12'b0};
         TypeJ: o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                         i_instr[30:21], 1'b0};
         default: o_imm = '0;
      endcase
   end

   // Register fields are raw bit slices; only an absent lane zeroes them.
   assign o_type    = w_type;
   assign o_rd      = i_present ? i_instr[11:7]  : 5'd0;
   assign o_rs1     = i_present ? i_instr[19:15] : 5'd0;
   assign o_rs2     = i_present ? i_instr[24:20] : 5'd0;
`ifdef DECODE_FP_EN
   assign o_rs3     = i_present ? i_instr[31:27] : 5'd0;
`endif
   assign o_illegal = i_present && (w_type == TypeUnknown);

endmodule

// File: rtl/instr_decode_stage.sv
// Multi-lane decode stage: output register plus skid register, and a saturating illegal count.
// Defining DECODE_FP_EN enables FP opcode decode and the out_rs3 port.
module instr_decode_stage
   import instr_decode_stage_pkg::*;
#(
   parameter int unsigned LANES = 2,
   parameter int unsigned CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*32-1:0]    in_instr,
   input  logic [LANES-1:0]       in_mask,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*TYPE_W-1:0] out_type,
   output logic [LANES*32-1:0]    out_imm,
   output logic [LANES*5-1:0]     out_rd,
   output logic [LANES*5-1:0]     out_rs1,
   output logic [LANES*5-1:0]     out_rs2,
`ifdef DECODE_FP_EN
   output logic [LANES*5-1:0]     out_rs3,
`endif
   output logic [LANES-1:0]       out_mask,
   output logic [LANES-1:0]       out_illegal,
   input  logic                   clr_cnt,
   output logic [CNT_W-1:0]       ill_cnt
);

`ifdef DECODE_FP_EN
   localparam int unsigned REG_N = 4;
`else
   localparam int unsigned REG_N = 3;
`endif
   localparam int unsigned PAY_W  = LANES * (32 + 5 * REG_N + 2);
   localparam int unsigned BEAT_W = LANES * TYPE_W + PAY_W;
   localparam logic [TYPE_W-1:0] TYPE_UNK = TypeUnknown;
   localparam logic [BEAT_W-1:0] BEAT_RST = {{LANES{TYPE_UNK}}, {PAY_W{1'b0}}};

   logic [LANES*TYPE_W-1:0] w_type;
   logic [LANES*32-1:0]     w_imm;
   logic [LANES*5-1:0]      w_rd;
   logic [LANES*5-1:0]      w_rs1;
   logic [LANES*5-1:0]      w_rs2;
`ifdef DECODE_FP_EN
   logic [LANES*5-1:0]      w_rs3;
`endif
   logic [LANES-1:0]        w_illegal;
   logic [BEAT_W-1:0]       w_beat;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      instr_lane_decode u_dec (
         .i_present (in_mask[l]),
         .i_instr   (in_instr[l*32 +: 32]),
         .o_type    (w_type[l*TYPE_W +: TYPE_W]),
         .o_imm     (w_imm[l*32 +: 32]),
         .o_rd      (w_rd[l*5 +: 5]),
         .o_rs1     (w_rs1[l*5 +: 5]),
         .o_rs2     (w_rs2[l*5 +: 5]),
`ifdef DECODE_FP_EN
         .o_rs3     (w_rs3[l*5 +: 5]),
`endif
         .o_illegal (w_illegal[l])
      );
   end

   assign w_beat = {w_type, w_imm, w_rd, w_rs1, w_rs2,
`ifdef DECODE_FP_EN
                    w_rs3,
`endif
                    in_mask, w_illegal};

   logic              r_out_valid;
   logic [BEAT_W-1:0] r_out_beat;
   logic              r_skid_valid;
   logic [BEAT_W-1:0] r_skid_beat;
   logic [CNT_W-1:0]  r_ill_cnt;

   logic              w_out_valid_d;
   logic [BEAT_W-1:0] w_out_beat_d;
   logic              w_skid_valid_d;
   logic [BEAT_W-1:0] w_skid_beat_d;
   logic [CNT_W-1:0]  w_ill_cnt_d;
   logic              w_accept;
   logic              w_out_free;
   logic [2:0]        w_ill_pop;
   logic [CNT_W:0]    w_cnt_sum;

   // in_ready comes straight from the skid flop, so it never sees out_ready combinationally.
   assign in_ready   = ~r_skid_valid;
   assign w_accept   = in_valid & in_ready;
   assign w_out_free = ~r_out_valid | out_ready;

   always_comb begin
      w_out_valid_d  = r_out_valid;
      w_out_beat_d   = r_out_beat;
      w_skid_valid_d = r_skid_valid;
      w_skid_beat_d  = r_skid_beat;
      if (w_out_free) begin
         if (r_skid_valid) begin
            w_out_valid_d  = 1'b1;
            w_out_beat_d   = r_skid_beat;
            w_skid_valid_d = 1'b0;
         end else begin
            w_out_valid_d = w_accept;
            if (w_accept) begin
               w_out_beat_d = w_beat;
            end
         end
      end else if (w_accept) begin
         w_skid_valid_d = 1'b1;
         w_skid_beat_d  = w_beat;
      end
   end

   assign w_ill_pop = popcount4(4'(w_illegal));
   assign w_cnt_sum = {1'b0, r_ill_cnt} + (CNT_W + 1)'(w_ill_pop);

   always_comb begin
      w_ill_cnt_d = r_ill_cnt;
      if (clr_cnt) begin
         w_ill_cnt_d = '0;
      end else if (w_accept) begin
         w_ill_cnt_d = w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_out_beat   <= BEAT_RST;
         r_skid_valid <= 1'b0;
         r_skid_beat  <= BEAT_RST;
         r_ill_cnt    <= '0;
      end else begin
         r_out_valid  <= w_out_valid_d;
         r_out_beat   <= w_out_beat_d;
         r_skid_valid <= w_skid_valid_d;
         r_skid_beat  <= w_skid_beat_d;
         r_ill_cnt    <= w_ill_cnt_d;
      end
   end

   assign out_valid = r_out_valid;
   assign ill_cnt   = r_ill_cnt;
   assign {out_type, out_imm, out_rd, out_rs1, out_rs2,
`ifdef DECODE_FP_EN
           out_rs3,
`endif
           out_mask, out_illegal} = r_out_beat;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage with LANES=2, CNT_W=4.
// Expectations follow DECODE_FP_EN when it is defined.
module tb_instr_decode_stage;

   localparam int unsigned LANES = 2;
   localparam int unsigned CNT_W = 4;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 in_valid;
   logic                 in_ready;
   logic [LANES*32-1:0]  in_instr;
   logic [LANES-1:0]     in_mask;
   logic                 out_valid;
   logic                 out_ready;
   logic [LANES*3-1:0]   out_type;
   logic [LANES*32-1:0]  out_imm;
   logic [LANES*5-1:0]   out_rd;
   logic [LANES*5-1:0]   out_rs1;
   logic [LANES*5-1:0]   out_rs2;
`ifdef DECODE_FP_EN
   logic [LANES*5-1:0]   out_rs3;
`endif
   logic [LANES-1:0]     out_mask;
   logic [LANES-1:0]     out_illegal;
   logic                 clr_cnt;
   logic [CNT_W-1:0]     ill_cnt;

   int n_err = 0;
   int n_chk = 0;
   int exp_cnt;

   always #5 clk = ~clk;

   instr_decode_stage #(
      .LANES (LANES),
      .CNT_W (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_mask     (in_mask),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_type    (out_type),
      .out_imm     (out_imm),
      .out_rd      (out_rd),
      .out_rs1     (out_rs1),
      .out_rs2     (out_rs2),
`ifdef DECODE_FP_EN
      .out_rs3     (out_rs3),
`endif
      .out_mask    (out_mask),
      .out_illegal (out_illegal),
      .clr_cnt     (clr_cnt),
      .ill_cnt     (ill_cnt)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] l0, input logic [31:0] l1, input logic [1:0] m);
      in_valid = 1'b1;
      in_instr = {l1, l0};
      in_mask  = m;
   endtask

   // Beat k: lane0 addi x1,x0,k ; lane1 lui x5,k
   task automatic drive_seq(input int k);
      drive((32'(k) << 20) | 32'h0000_0093, (32'(k) << 12) | 32'h0000_02B7, 2'b11);
   endtask

   initial begin
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_mask   = '0;
      out_ready = 1'b0;
      clr_cnt   = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_ill_cnt",   64'(ill_cnt),   64'd0);
      check("rst_type",      64'(out_type),  64'h3F);
      check("rst_imm",       64'(out_imm),   64'd0);
      check("rst_rd",        64'(out_rd),    64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      check("rst_in_ready",  64'(in_ready),  64'd1);

      // addi x1,x0,5 / addi a0,a1,-4
      out_ready = 1'b1;
      drive(32'h0050_0093, 32'hFFC5_8513, 2'b11);
      tick();
      in_valid = 1'b0;
      check("addi_valid",   64'(out_valid),   64'd1);
      check("addi_type",    64'(out_type),    64'h09);
      check("addi_imm",     64'(out_imm),     64'hFFFFFFFC_00000005);
      check("addi_rd",      64'(out_rd),      64'h141);
      check("addi_rs1",     64'(out_rs1),     64'h160);
      check("addi_illegal", 64'(out_illegal), 64'd0);
      tick();
      check("addi_drained", 64'(out_valid),   64'd0);

      // all-zero word (illegal) / jal x0,0
      drive(32'h0000_0000, 32'h0000_006F, 2'b11);
      tick();
      in_valid = 1'b0;
      check("ill_illegal", 64'(out_illegal), 64'h1);
      check("ill_type",    64'(out_type),    64'h2F);
      check("ill_imm",     64'(out_imm),     64'd0);
      check("ill_cnt1",    64'(ill_cnt),     64'd1);
      tick();

      // add x3,x4,x5 / sw x5,-8(x2)
      drive(32'h0052_01B3, 32'hFE51_2C23, 2'b11);
      tick();
      in_valid = 1'b0;
      check("rs_type", 64'(out_type), 64'h10);
      check("rs_imm",  64'(out_imm),  64'hFFFFFFF8_00000000);
      check("rs_rs1",  64'(out_rs1),  64'h044);
      check("rs_rs2",  64'(out_rs2),  64'h0A5);
      check("rs_rd",   64'(out_rd),   64'h303);
      tick();

      // beq x0,x0,-4 / jal x1,2048
      drive(32'hFE00_0EE3, 32'h0010_00EF, 2'b11);
      tick();
      in_valid = 1'b0;
      check("bj_type", 64'(out_type), 64'h2B);
      check("bj_imm",  64'(out_imm),  64'h00000800_FFFFFFFC);
      tick();

      // Backpressure: two beats held, third refused until drain
      out_ready = 1'b0;
      drive_seq(1);
      check("bp_ready0", 64'(in_ready), 64'd1);
      tick();
      drive_seq(2);
      check("bp_ready1", 64'(in_ready), 64'd1);
      tick();
      check("bp_ready_full", 64'(in_ready),  64'd0);
      check("bp_valid",      64'(out_valid), 64'd1);
      check("bp_beat1",      64'(out_imm),   64'h00001000_00000001);
      drive_seq(3);
      tick();
      check("bp_hold_beat1", 64'(out_imm),   64'h00001000_00000001);
      check("bp_hold_ready", 64'(in_ready),  64'd0);
      out_ready = 1'b1;
      tick();
      check("bp_beat2",      64'(out_imm),   64'h00002000_00000002);
      check("bp_ready_back", 64'(in_ready),  64'd1);
      tick();
      in_valid = 1'b0;
      check("bp_beat3",      64'(out_imm),   64'h00003000_00000003);
      check("bp_beat3_vld",  64'(out_valid), 64'd1);
      tick();
      check("bp_empty",      64'(out_valid), 64'd0);
      check("bp_cnt",        64'(ill_cnt),   64'd1);

      // Empty mask still forms a beat
      drive(32'h0000_0000, 32'h0000_0000, 2'b00);
      tick();
      in_valid = 1'b0;
      check("m0_valid",   64'(out_valid),   64'd1);
      check("m0_mask",    64'(out_mask),    64'd0);
      check("m0_type",    64'(out_type),    64'h3F);
      check("m0_illegal", 64'(out_illegal), 64'd0);
      check("m0_cnt",     64'(ill_cnt),     64'd1);
      tick();

      // fadd.s f10,f10,f11 on lane0, lane1 absent
      drive(32'h00B5_0553, 32'h0000_0000, 2'b01);
      tick();
      in_valid = 1'b0;
`ifdef DECODE_FP_EN
      exp_cnt = 1;
      check("fp_type",    64'(out_type),    64'h38);
      check("fp_illegal", 64'(out_illegal), 64'd0);
      check("fp_rs3",     64'(out_rs3),     64'd0);
`else
      exp_cnt = 2;
      check("fp_type",    64'(out_type),    64'h3F);
      check("fp_illegal", 64'(out_illegal), 64'h1);
`endif
      check("fp_cnt",     64'(ill_cnt),     64'(exp_cnt));
      tick();

      // Saturation at 2^CNT_W-1 and clear priority
      drive(32'h0000_0000, 32'h0000_0000, 2'b01);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i == 0) check("sat_first", 64'(ill_cnt), 64'(exp_cnt + 1));
      end
      check("sat_stop", 64'(ill_cnt), 64'd15);
      clr_cnt = 1'b1;
      tick();
      check("clr_wins", 64'(ill_cnt), 64'd0);
      clr_cnt = 1'b0;
      tick();
      check("clr_resume", 64'(ill_cnt), 64'd1);
      in_valid = 1'b0;
      tick();

      // Reset with both registers full
      out_ready = 1'b0;
      drive_seq(4);
      tick();
      drive_seq(5);
      tick();
      in_valid = 1'b0;
      check("rr_full",  64'(in_ready),  64'd0);
      check("rr_valid", 64'(out_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rr_valid_now", 64'(out_valid), 64'd0);
      check("rr_cnt",       64'(ill_cnt),   64'd0);
      check("rr_type",      64'(out_type),  64'h3F);
      check("rr_imm",       64'(out_imm),   64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("rr_ready",     64'(in_ready),  64'd1);
      check("rr_no_beat",   64'(out_valid), 64'd0);
      out_ready = 1'b1;
      tick();
      check("rr_no_skid",   64'(out_valid), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
